// File: rtl/cu_astat_if.sv
// Bus access port of the arithmetic status stage:
// write strobes, write data and ASTAT/STKY readback.
interface cu_astat_if #(
    parameter int DATA_WIDTH = 16
);
    logic                  ps_astat_wen;
    logic                  ps_stky_wen;
    logic [DATA_WIDTH-1:0] xb_dt;
    logic [DATA_WIDTH-1:0] astat_xb_dt;
    logic [DATA_WIDTH-1:0] stky_xb_dt;

    modport master (
        output ps_astat_wen,
        output ps_stky_wen,
        output xb_dt,
        input  astat_xb_dt,
        input  stky_xb_dt
    );

    modport slave (
        input  ps_astat_wen,
        input  ps_stky_wen,
        input  xb_dt,
        output astat_xb_dt,
        output stky_xb_dt
    );
endinterface

// File: rtl/cu_astat.sv
// Arithmetic status stage: ASTAT/STKY capture from the ALU,
// compare accumulator and sequencer condition evaluation.
module cu_astat #(
    parameter int DATA_WIDTH = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps_alu_en,
    input  logic       alu_ps_az,
    input  logic       alu_ps_an,
    input  logic       alu_ps_ac,
    input  logic       alu_ps_av,
    input  logic       alu_ps_compd,
    input  logic [3:0] ps_cond,
    output logic       astat_ps_cond,
    cu_astat_if.slave  bus
);

    logic       alu_vld_q;
    logic       alu_vld_d;
    logic [3:0] flg_q;
    logic [3:0] flg_d;
    logic [7:0] cacc_q;
    logic [7:0] cacc_d;
    logic [1:0] stky_q;
    logic [1:0] stky_d;

    logic [3:0] flg_eff;
    logic [7:0] cacc_eff;
    logic [1:0] stky_eff;
    logic [1:0] stky_set;
    logic       cmp_gt;
    logic       cond_base;

    logic [DATA_WIDTH-1:0] astat_rd;
    logic [DATA_WIDTH-1:0] stky_rd;
    logic                  unused_xb;

    // Flag order in flg_*: {AV, AC, AN, AZ}; sticky order: {ACS, AVS}.
    always_comb begin
        cmp_gt   = ~alu_ps_az & ~alu_ps_an;
        stky_set = 2'b00;
        flg_eff  = flg_q;
        cacc_eff = cacc_q;
        if (alu_vld_q) begin
            stky_set = {alu_ps_ac, alu_ps_av};
            flg_eff  = {alu_ps_av, alu_ps_ac, alu_ps_an, alu_ps_az};
            if (alu_ps_compd) begin
                cacc_eff = {cacc_q[6:0], cmp_gt};
            end
        end
        stky_eff = stky_q | stky_set;
    end

    always_comb begin
        alu_vld_d = ps_alu_en;
        flg_d     = flg_eff;
        cacc_d    = cacc_eff;
        stky_d    = stky_eff;
        // A bus write overrides the whole ASTAT update.
        if (bus.ps_astat_wen) begin
            flg_d  = bus.xb_dt[3:0];
            cacc_d = bus.xb_dt[15:8];
        end
        // Sticky sets from the ALU survive a clearing write.
        if (bus.ps_stky_wen) begin
            stky_d = bus.xb_dt[1:0] | stky_set;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            alu_vld_q <= 1'b0;
            flg_q     <= 4'h0;
            cacc_q    <= 8'h00;
            stky_q    <= 2'b00;
        end else begin
            alu_vld_q <= alu_vld_d;
            flg_q     <= flg_d;
            cacc_q    <= cacc_d;
            stky_q    <= stky_d;
        end
    end

    always_comb begin
        cond_base = 1'b0;
        unique case (ps_cond[2:0])
            3'd0: cond_base = flg_eff[0];
            3'd1: cond_base = flg_eff[1] & ~flg_eff[0];
            3'd2: cond_base = flg_eff[1] | flg_eff[0];
            3'd3: cond_base = flg_eff[2];
            3'd4: cond_base = flg_eff[3];
            3'd5: cond_base = cacc_eff[0];
            3'd6: cond_base = stky_eff[0];
            3'd7: cond_base = 1'b1;
        endcase
        astat_ps_cond = cond_base ^ ps_cond[3];
    end

    always_comb begin
        astat_rd        = '0;
        astat_rd[15:0]  = {cacc_q, 4'h0, flg_q};
        stky_rd         = '0;
        stky_rd[1:0]    = stky_q;
    end

    assign bus.astat_xb_dt = astat_rd;
    assign bus.stky_xb_dt  = stky_rd;
    assign unused_xb       = ^bus.xb_dt;

endmodule
